// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, state type and the BYPASS opcode helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_RTI     = 4'h0,
        ST_SEL_DR  = 4'h1,
        ST_CAP_DR  = 4'h2,
        ST_SH_DR   = 4'h3,
        ST_EX1_DR  = 4'h4,
        ST_PAUSE_DR = 4'h5,
        ST_EX2_DR  = 4'h6,
        ST_UPD_DR  = 4'h7,
        ST_SEL_IR  = 4'h8,
        ST_CAP_IR  = 4'h9,
        ST_SH_IR   = 4'hA,
        ST_EX1_IR  = 4'hB,
        ST_PAUSE_IR = 4'hC,
        ST_EX2_IR  = 4'hD,
        ST_UPD_IR  = 4'hE,
        ST_TLR     = 4'hF
    } tap_state_t;

    // All-ones opcode of the given IR width; callers truncate to their width.
    function automatic logic [31:0] bypass_op(input int unsigned width);
        bypass_op = (32'h0000_0001 << width) - 32'h0000_0001;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 sixteen-state TAP controller; TRST is synchronous and active-high.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t STATE
);

    tap_state_t state_r;
    tap_state_t state_next_s;

    // Next-state decode of the TMS transition graph
    always_comb begin
        state_next_s = ST_TLR;
        case (state_r)
            ST_TLR:      state_next_s = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:      state_next_s = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   state_next_s = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   state_next_s = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    state_next_s = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   state_next_s = TMS ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next_s = TMS ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   state_next_s = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   state_next_s = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   state_next_s = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   state_next_s = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    state_next_s = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   state_next_s = TMS ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next_s = TMS ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   state_next_s = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   state_next_s = TMS ? ST_SEL_DR : ST_RTI;
            default:     state_next_s = ST_TLR;
        endcase
    end

    // State register; TRST overrides TMS
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign STATE = state_r;

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP with IR, BYPASS, optional IDCODE (macro JTAG_IDCODE_EN) and TDO mux over NUM_DR user chains.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH   = 4,
    parameter int unsigned NUM_DR     = 2,
    parameter int unsigned USER_BASE  = 4,
    parameter int unsigned IDCODE_OP  = 1,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0ABD
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          STATE,
    output logic [IR_WIDTH-1:0] IR_OUT,
    output logic [NUM_DR-1:0]   DR_SEL,
    output logic                CAPTURE_DR,
    output logic                SHIFT_DR,
    output logic                UPDATE_DR,
    input  logic [NUM_DR-1:0]   DR_TDO,
    output logic                RTI
);

    localparam logic [IR_WIDTH-1:0] BYPASS_OP  = IR_WIDTH'(bypass_op(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(IDCODE_OP);
    localparam logic [IR_WIDTH-1:0] RESET_OP    = IDCODE_CODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OP    = BYPASS_OP;
`endif

    if ((IR_WIDTH < 32'd2) || (NUM_DR < 32'd1) ||
        (NUM_DR > ((32'd1 << IR_WIDTH) - 32'd2)) ||
        (IDCODE_OP >= (32'd1 << IR_WIDTH)) || (IDCODE_VAL[0] != 1'b1)) begin : g_param_err
        $error("jtag_tap: illegal parameter set");
    end

    tap_state_t          state_s;
    logic [IR_WIDTH-1:0] ir_shift_r;
    logic [IR_WIDTH-1:0] ir_r;
    logic [IR_WIDTH-1:0] ir_next_s;
    logic [NUM_DR-1:0]   dr_sel_r;
    logic                bypass_r;
    logic                user_sel_s;
    logic                idcode_sel_s;
    logic                idcode_tdo_s;

    // One-hot user chain decode; undecoded opcodes give all-zero (BYPASS)
    function automatic logic [NUM_DR-1:0] user_decode(input logic [IR_WIDTH-1:0] op);
        user_decode = {NUM_DR{1'b0}};
        for (int k = 0; k < NUM_DR; k++) begin
            user_decode[k] = (op == IR_WIDTH'(USER_BASE + k));
        end
    endfunction

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .STATE (state_s)
    );

    // Active-instruction next value: reset instruction in TLR, shift register in UpdIR
    always_comb begin
        ir_next_s = ir_r;
        if (state_s == ST_TLR) begin
            ir_next_s = RESET_OP;
        end else if (state_s == ST_UPD_IR) begin
            ir_next_s = ir_shift_r;
        end else begin
            ir_next_s = ir_r;
        end
    end

    // IR shift register, active instruction and its registered chain select
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_shift_r <= {IR_WIDTH{1'b0}};
            ir_r       <= RESET_OP;
            dr_sel_r   <= user_decode(RESET_OP);
        end else begin
            ir_r     <= ir_next_s;
            dr_sel_r <= user_decode(ir_next_s);
            if (state_s == ST_CAP_IR) begin
                ir_shift_r <= IR_CAPTURE;
            end else if (state_s == ST_SH_IR) begin
                ir_shift_r <= {TDI, ir_shift_r[IR_WIDTH-1:1]};
            end
        end
    end

    // BYPASS bit: cleared on capture, follows TDI while shifting
    always_ff @(posedge TCK) begin
        if (TRST) begin
            bypass_r <= 1'b0;
        end else if (state_s == ST_CAP_DR) begin
            bypass_r <= 1'b0;
        end else if (state_s == ST_SH_DR) begin
            bypass_r <= TDI;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_r;

    // IDCODE register: loads the device ID on capture, shifts right from TDI
    always_ff @(posedge TCK) begin
        if (TRST) begin
            idcode_r <= 32'h0000_0000;
        end else if (state_s == ST_CAP_DR) begin
            idcode_r <= IDCODE_VAL;
        end else if (state_s == ST_SH_DR) begin
            idcode_r <= {TDI, idcode_r[31:1]};
        end
    end

    assign idcode_sel_s = (ir_r == IDCODE_CODE);
    assign idcode_tdo_s = idcode_r[0];
`else
    assign idcode_sel_s = 1'b0;
    assign idcode_tdo_s = 1'b0;
`endif

    assign user_sel_s = |dr_sel_r;

    // TDO mux: IR LSB in ShIR, selected data register in ShDR, quiet elsewhere
    always_comb begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
        case (state_s)
            ST_SH_IR: begin
                TDO    = ir_shift_r[0];
                TDO_EN = 1'b1;
            end
            ST_SH_DR: begin
                TDO_EN = 1'b1;
                if (user_sel_s) begin
                    TDO = |(DR_TDO & dr_sel_r);
                end else if (idcode_sel_s) begin
                    TDO = idcode_tdo_s;
                end else begin
                    TDO = bypass_r;
                end
            end
            default: begin
                TDO    = 1'b0;
                TDO_EN = 1'b0;
            end
        endcase
    end

    assign CAPTURE_DR = user_sel_s && (state_s == ST_CAP_DR);
    assign SHIFT_DR   = user_sel_s && (state_s == ST_SH_DR);
    assign UPDATE_DR  = user_sel_s && (state_s == ST_UPD_DR);
    assign RTI        = (state_s == ST_RTI);
    assign STATE      = state_s;
    assign IR_OUT     = ir_r;
    assign DR_SEL     = dr_sel_r;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: behavioural TAP model plus directed scans with literal expectations.
module tb_jtag_tap;

    localparam int          IRW   = 4;
    localparam int          NDR   = 2;
    localparam int          UBASE = 4;
    localparam int          IDOP  = 1;
    localparam logic [31:0] IDVAL = 32'h1000_0ABD;
`ifdef JTAG_IDCODE_EN
    localparam bit HAS_ID = 1'b1;
`else
    localparam bit HAS_ID = 1'b0;
`endif
    localparam int RESET_IR = HAS_ID ? IDOP : 15;

    logic           TCK = 1'b0;
    logic           TRST = 1'b1;
    logic           TMS = 1'b1;
    logic           TDI = 1'b0;
    logic [NDR-1:0] DR_TDO = '0;
    logic           TDO, TDO_EN, CAPTURE_DR, SHIFT_DR, UPDATE_DR, RTI;
    logic [3:0]     STATE;
    logic [IRW-1:0] IR_OUT;
    logic [NDR-1:0] DR_SEL;

    jtag_tap dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .STATE(STATE), .IR_OUT(IR_OUT), .DR_SEL(DR_SEL), .CAPTURE_DR(CAPTURE_DR),
        .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR), .DR_TDO(DR_TDO), .RTI(RTI)
    );

    always #5 TCK = ~TCK;

    // TAP graph as successor tables indexed by state code
    int nx0[16] = '{0, 2, 3, 3, 5, 5, 3, 0, 9, 10, 10, 12, 12, 10, 0, 0};
    int nx1[16] = '{1, 8, 4, 4, 7, 6, 7, 1, 15, 11, 11, 14, 13, 14, 1, 15};

    int          m_state = 15;
    int          m_ir = RESET_IR;
    int          m_irsh = 0;
    int          m_byp = 0;
    logic [31:0] m_id = 32'h0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cap_cnt = 0;
    int          sh_cnt = 0;
    int          upd_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_sel();
        if (m_ir >= UBASE && m_ir < UBASE + NDR) return m_ir - UBASE;
        return -1;
    endfunction

    task automatic model_update(input logic trst, input logic tms, input logic tdi);
        if (trst) begin
            m_state = 15; m_ir = RESET_IR; m_irsh = 0; m_byp = 0; m_id = 32'h0;
        end else begin
            case (m_state)
                9:  m_irsh = 1;
                10: m_irsh = (m_irsh >> 1) | (int'(tdi) << (IRW - 1));
                2:  begin m_byp = 0; m_id = IDVAL; end
                3:  begin m_byp = int'(tdi); m_id = {tdi, m_id[31:1]}; end
                14: m_ir = m_irsh;
                15: m_ir = RESET_IR;
                default: ;
            endcase
            m_state = tms ? nx1[m_state] : nx0[m_state];
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge TCK) begin
        int   sel;
        logic e_tdo;
        cap_cnt += (CAPTURE_DR === 1'b1) ? 1 : 0;
        sh_cnt  += (SHIFT_DR === 1'b1) ? 1 : 0;
        upd_cnt += (UPDATE_DR === 1'b1) ? 1 : 0;
        if (chk_en) begin
            sel   = m_sel();
            e_tdo = 1'b0;
            if (m_state == 10) e_tdo = m_irsh[0];
            else if (m_state == 3) begin
                if (sel >= 0) e_tdo = DR_TDO[sel];
                else if (HAS_ID && m_ir == IDOP) e_tdo = m_id[0];
                else e_tdo = m_byp[0];
            end
            chk("STATE", 32'(STATE), m_state);
            chk("IR_OUT", 32'(IR_OUT), m_ir);
            chk("DR_SEL", 32'(DR_SEL), (sel >= 0) ? (1 << sel) : 0);
            chk("TDO", 32'(TDO), 32'(e_tdo));
            chk("TDO_EN", 32'(TDO_EN), (m_state == 3 || m_state == 10) ? 1 : 0);
            chk("CAPTURE_DR", 32'(CAPTURE_DR), (m_state == 2 && sel >= 0) ? 1 : 0);
            chk("SHIFT_DR", 32'(SHIFT_DR), (m_state == 3 && sel >= 0) ? 1 : 0);
            chk("UPDATE_DR", 32'(UPDATE_DR), (m_state == 7 && sel >= 0) ? 1 : 0);
            chk("RTI", 32'(RTI), (m_state == 0) ? 1 : 0);
        end
    end

    task automatic step(input logic trst, input logic tms, input logic tdi);
        TRST = trst; TMS = tms; TDI = tdi;
        DR_TDO = NDR'($urandom_range(0, 3));
        @(posedge TCK);
        model_update(trst, tms, tdi);
        @(negedge TCK);
        #1;
    endtask

    // Called in ShDR/ShIR: samples TDO, shifts din LSB-first, exits to Exit1 on last bit
    task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = 32'h0;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            step(1'b0, (i == n - 1), din[i]);
        end
    endtask

    task automatic to_shdr();  // from RTI
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic to_shir();  // from RTI
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic exit_to_rti();  // from Exit1
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] din;
        int c0, s0, u0;

        step(1'b1, 1'b1, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("rst_state", 32'(STATE), 32'hF);
        chk("rst_ir", 32'(IR_OUT), RESET_IR);
        chk("rst_tdo_en", 32'(TDO_EN), 32'h0);

        step(1'b0, 1'b0, 1'b0);
        chk("rti_state", 32'(STATE), 32'h0);
        chk("rti_flag", 32'(RTI), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        chk("five_tms_tlr", 32'(STATE), 32'hF);
        step(1'b0, 1'b0, 1'b0);

        // DR scan straight after reset: IDCODE or BYPASS depending on build
        din = 32'h1234_5679;
        to_shdr();
        shift(32, din, d);
        exit_to_rti();
        chk("reset_dr_scan", d, HAS_ID ? IDVAL : {din[30:0], 1'b0});

        // IR scan selecting user chain 1
        to_shir();
        shift(4, 32'h5, d);
        chk("ir_capture", d, 32'h1);
        exit_to_rti();
        chk("ir_user1", 32'(IR_OUT), 32'h5);
        chk("dr_sel_user1", 32'(DR_SEL), 32'h2);

        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        to_shdr();
        shift(6, 32'h2D, d);
        exit_to_rti();
        chk("user_cap_cnt", cap_cnt - c0, 32'h1);
        chk("user_sh_cnt", sh_cnt - s0, 32'h6);
        chk("user_upd_cnt", upd_cnt - u0, 32'h1);

        // BYPASS: A5 comes back one bit late behind a leading 0
        to_shir();
        shift(4, 32'hF, d);
        exit_to_rti();
        chk("ir_bypass", 32'(IR_OUT), 32'hF);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        to_shdr();
        shift(8, 32'hA5, d);
        exit_to_rti();
        chk("bypass_a5", d, 32'h4A);
        chk("bypass_no_strobes", (cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0), 32'h0);

        // IR scan of 4'b0100 interrupted through PauseIR for three cycles
        to_shir();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pause_ir", 32'(STATE), 32'hC);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        exit_to_rti();
        chk("ir_after_pause", 32'(IR_OUT), 32'h4);
        chk("dr_sel_user0", 32'(DR_SEL), 32'h1);

        // TRST in the middle of a user DR shift
        to_shdr();
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("trst_state", 32'(STATE), 32'hF);
        chk("trst_dr_sel", 32'(DR_SEL), 32'h0);
        chk("trst_tdo_en", 32'(TDO_EN), 32'h0);
        chk("trst_ir", 32'(IR_OUT), RESET_IR);

        step(1'b0, 1'b1, 1'b0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
